mem_port_arbiter: RTL and testbench

- Shares one single-ported memory port between the core's instruction-fetch requester and its data (memAction) requester.
- Sits between the processor top and the RAM model, replacing today's dual-port hookup.
- One outstanding memory transaction at a time.
- Data has priority, with anti-starvation for fetch.
- Misaligned-fetch and timeout faults are generated locally.

---
 rtl/mem_arb_pkg.sv | 44 ++++
 rtl/mem_arb_priority.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Request/response layouts match the memCtrl and dResp bundles.
package mem_arb_pkg;

   localparam logic [1:0] MEMOP_NONE  = 2'b00;
   localparam logic [1:0] MEMOP_LOAD  = 2'b01;
   localparam logic [1:0] MEMOP_STORE = 2'b10;

   localparam logic [1:0] FAULT_NONE       = 2'b00;
   localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } arb_state_t;

   typedef enum logic {
      OWN_DATA,
      OWN_FETCH
   } arb_owner_t;

   typedef struct packed {
      logic [1:0]  op;
      logic [7:0]  mask;
      logic [63:0] addr;
      logic [63:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  fault;
   } mem_resp_t;

   function automatic logic [31:0] pick_word(
      input logic [63:0] d,
      input logic        hi
   );
      return hi ? d[63:32] : d[31:0];
   endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection between fetch and data, with a streak counter
// that hands the port to a waiting fetch after a run of data grants.
module mem_arb_priority
   import mem_arb_pkg::*;
#(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic CLK,
   input  logic RESET,
   input  logic i_grant_en,
   input  logic i_fetch_valid,
   input  logic i_data_valid,
   output logic o_grant_fetch,
   output logic o_grant_data
);

   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   logic [SW-1:0] r_streak;
   logic          w_force_fetch;

   always_comb begin
      w_force_fetch = (r_streak == STREAK_MAX) && i_fetch_valid;
      o_grant_data  = i_grant_en && i_data_valid && !w_force_fetch;
      o_grant_fetch = i_grant_en && i_fetch_valid && !o_grant_data;
   end

   // The streak only measures data grants made while fetch is waiting.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_streak <= '0;
      end else if (o_grant_fetch || !i_fetch_valid) begin
         r_streak <= '0;
      end else if (o_grant_data && (r_streak != STREAK_MAX)) begin
         r_streak <= r_streak + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data
// access; one transaction in flight, local misalign/timeout faults.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        i_req_valid,
   output logic        i_req_ready,
   input  logic [63:0] i_req_addr,
   output logic        i_resp_valid,
   output logic [31:0] i_resp_instr,
   output logic [1:0]  i_resp_fault,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic [1:0]  d_req_op,
   input  logic [7:0]  d_req_mask,
   input  logic [63:0] d_req_addr,
   input  logic [63:0] d_req_wdata,
   output logic        d_resp_valid,
   output logic [63:0] d_resp_data,
   output logic [1:0]  d_resp_fault,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [1:0]  mem_req_op,
   output logic [7:0]  mem_req_mask,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_data,
   input  logic [1:0]  mem_resp_fault,
   output logic        err_unexpected_resp
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);

   arb_state_t    r_state;
   arb_state_t    w_state_nxt;
   arb_owner_t    r_owner;
   arb_owner_t    w_owner_nxt;
   mem_req_t      r_req;
   mem_req_t      w_req_nxt;
   mem_resp_t     r_resp;
   mem_resp_t     w_resp_nxt;
   logic          r_pc2;
   logic          w_pc2_nxt;
   logic [TW-1:0] r_tcnt;
   logic [TW-1:0] w_tcnt_nxt;
   logic [TW-1:0] w_tcnt_inc;
   logic          r_err;
   logic          w_err_nxt;

   logic w_idle;
   logic w_issue;
   logic w_resp;
   logic w_gnt_f;
   logic w_gnt_d;

   assign w_idle  = RESET && (r_state == ST_IDLE);
   assign w_issue = RESET && (r_state == ST_ISSUE);
   assign w_resp  = RESET && (r_state == ST_RESP);

   mem_arb_priority #(
      .MAX_DATA_STREAK(MAX_DATA_STREAK)
   ) u_prio (
      .CLK           (CLK),
      .RESET         (RESET),
      .i_grant_en    (w_idle),
      .i_fetch_valid (i_req_valid),
      .i_data_valid  (d_req_valid),
      .o_grant_fetch (w_gnt_f),
      .o_grant_data  (w_gnt_d)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_req_nxt   = r_req;
      w_resp_nxt  = r_resp;
      w_pc2_nxt   = r_pc2;
      w_tcnt_nxt  = r_tcnt;
      w_err_nxt   = r_err;
      w_tcnt_inc  = r_tcnt + 1'b1;

      unique case (r_state)
         ST_IDLE: begin
            if (mem_resp_valid) begin
               w_err_nxt = 1'b1;
            end
            if (w_gnt_d) begin
               w_owner_nxt = OWN_DATA;
               w_req_nxt   = '{op: d_req_op, mask: d_req_mask,
                               addr: d_req_addr, wdata: d_req_wdata};
               w_state_nxt = ST_ISSUE;
            end else if (w_gnt_f) begin
               w_owner_nxt = OWN_FETCH;
               w_pc2_nxt   = i_req_addr[2];
               w_req_nxt   = '{op: MEMOP_LOAD, mask: 8'hFF,
                               addr: {i_req_addr[63:3], 3'b000},
                               wdata: 64'd0};
               // A misaligned PC never reaches the RAM.
               if (i_req_addr[1:0] != 2'b00) begin
                  w_resp_nxt  = '{data: 64'd0, fault: FAULT_MISALIGNED};
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (mem_req_ready) begin
               w_tcnt_nxt = '0;
               if (mem_resp_valid) begin
                  w_resp_nxt  = '{data: mem_resp_data, fault: mem_resp_fault};
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end else if (mem_resp_valid) begin
               w_err_nxt = 1'b1;
            end
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               w_resp_nxt  = '{data: mem_resp_data, fault: mem_resp_fault};
               w_state_nxt = ST_RESP;
            end else begin
               w_tcnt_nxt = w_tcnt_inc;
               if (w_tcnt_inc == T_LIMIT) begin
                  w_resp_nxt  = '{data: 64'd0, fault: FAULT_TIMEOUT};
                  w_state_nxt = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state <= ST_IDLE;
         r_owner <= OWN_DATA;
         r_req   <= '0;
         r_resp  <= '0;
         r_pc2   <= 1'b0;
         r_tcnt  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_req   <= w_req_nxt;
         r_resp  <= w_resp_nxt;
         r_pc2   <= w_pc2_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Outputs are forced quiet while reset is held.
   assign i_req_ready = w_gnt_f;
   assign d_req_ready = w_gnt_d;

   assign mem_req_valid = w_issue;
   assign mem_req_op    = w_issue ? r_req.op    : 2'b00;
   assign mem_req_mask  = w_issue ? r_req.mask  : 8'h00;
   assign mem_req_addr  = w_issue ? r_req.addr  : 64'd0;
   assign mem_req_wdata = w_issue ? r_req.wdata : 64'd0;

   assign i_resp_valid = w_resp && (r_owner == OWN_FETCH);
   assign i_resp_instr = i_resp_valid ? pick_word(r_resp.data, r_pc2) : 32'd0;
   assign i_resp_fault = i_resp_valid ? r_resp.fault : 2'b00;

   assign d_resp_valid = w_resp && (r_owner == OWN_DATA);
   assign d_resp_data  = d_resp_valid ? r_resp.data  : 64'd0;
   assign d_resp_fault = d_resp_valid ? r_resp.fault : 2'b00;

   assign err_unexpected_resp = RESET && r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random fetch/data traffic
// against a RAM model, plus streak, misalign, timeout and reset cases.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int MAXS = 4;
   localparam int TMO  = 8;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        i_req_ready;
   logic [63:0] i_req_addr = 64'd0;
   logic        i_resp_valid;
   logic [31:0] i_resp_instr;
   logic [1:0]  i_resp_fault;
   logic        d_req_valid = 1'b0;
   logic        d_req_ready;
   logic [1:0]  d_req_op = 2'b00;
   logic [7:0]  d_req_mask = 8'h00;
   logic [63:0] d_req_addr = 64'd0;
   logic [63:0] d_req_wdata = 64'd0;
   logic        d_resp_valid;
   logic [63:0] d_resp_data;
   logic [1:0]  d_resp_fault;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [1:0]  mem_req_op;
   logic [7:0]  mem_req_mask;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;
   logic [1:0]  mem_resp_fault;
   logic        err_unexpected_resp;

   mem_port_arbiter #(
      .MAX_DATA_STREAK(MAXS),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLK                 (CLK),
      .RESET               (RESET),
      .i_req_valid         (i_req_valid),
      .i_req_ready         (i_req_ready),
      .i_req_addr          (i_req_addr),
      .i_resp_valid        (i_resp_valid),
      .i_resp_instr        (i_resp_instr),
      .i_resp_fault        (i_resp_fault),
      .d_req_valid         (d_req_valid),
      .d_req_ready         (d_req_ready),
      .d_req_op            (d_req_op),
      .d_req_mask          (d_req_mask),
      .d_req_addr          (d_req_addr),
      .d_req_wdata         (d_req_wdata),
      .d_resp_valid        (d_resp_valid),
      .d_resp_data         (d_resp_data),
      .d_resp_fault        (d_resp_fault),
      .mem_req_valid       (mem_req_valid),
      .mem_req_ready       (mem_req_ready),
      .mem_req_op          (mem_req_op),
      .mem_req_mask        (mem_req_mask),
      .mem_req_addr        (mem_req_addr),
      .mem_req_wdata       (mem_req_wdata),
      .mem_resp_valid      (mem_resp_valid),
      .mem_resp_data       (mem_resp_data),
      .mem_resp_fault      (mem_resp_fault),
      .err_unexpected_resp (err_unexpected_resp)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        fetch;
      logic        misal;
      logic [63:0] data;
      logic [31:0] instr;
      logic [1:0]  fault;
      int          acc_cyc;
   } exp_t;

   exp_t     exp_q[$];
   mem_req_t mreq_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int streak = 0;
   int forced = 0;
   bit busy = 1'b0;
   int ram_mode = 0;
   int inject_req = 0;

   function automatic logic [63:0] ram_word(input logic [63:0] a);
      if (a == 64'h1000) return 64'hAAAA_BBBB_CCCC_DDDD;
      return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]} + a;
   endfunction

   function automatic logic [1:0] ram_fault(input logic [63:0] a);
      return (a[7:4] == 4'hF) ? 2'b10 : 2'b00;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // RAM model: mode 0 random ready/latency, 1 immediate, 2 never answers.
   initial begin : ram
      int          lat;
      int          inject_done;
      bit          pend;
      logic [63:0] ra;
      lat = 0;
      inject_done = 0;
      pend = 1'b0;
      ra = 64'd0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data = 64'd0;
      mem_resp_fault = 2'b00;
      forever begin
         @(posedge CLK);
         #1;
         mem_req_ready = 1'b0;
         mem_resp_valid = 1'b0;
         mem_resp_data = 64'd0;
         mem_resp_fault = 2'b00;
         if (inject_req != inject_done) begin
            inject_done = inject_req;
            mem_resp_valid = 1'b1;
            mem_resp_data = 64'hDEAD_0000_BEEF_0000;
         end else if (pend) begin
            if (lat == 0) begin
               pend = 1'b0;
               mem_resp_valid = 1'b1;
               mem_resp_data = ram_word(ra);
               mem_resp_fault = ram_fault(ra);
            end else begin
               lat--;
            end
         end else if (mem_req_valid &&
                      (ram_mode != 0 || $urandom_range(0, 2) != 0)) begin
            mem_req_ready = 1'b1;
            if (ram_mode != 2) begin
               ra = mem_req_addr;
               lat = (ram_mode == 1) ? 0 : int'($urandom_range(0, 3));
               if (lat == 0) begin
                  mem_resp_valid = 1'b1;
                  mem_resp_data = ram_word(ra);
                  mem_resp_fault = ram_fault(ra);
               end else begin
                  lat--;
                  pend = 1'b1;
               end
            end
         end
      end
   end

   // Monitor: reference arbitration model plus response scoreboard.
   initial begin : monitor
      exp_t        e;
      mem_req_t    m;
      int          ew;
      logic [63:0] a;
      logic [63:0] w;
      forever begin
         @(negedge CLK);
         cyc++;
         if (!RESET) begin
            exp_q.delete();
            mreq_q.delete();
            busy = 1'b0;
            streak = 0;
         end else begin
            if (mem_req_valid && mem_req_ready) begin
               hs_cyc = cyc;
               if (mreq_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL mem_req: got request addr %h expected none",
                           mem_req_addr);
               end else begin
                  m = mreq_q.pop_front();
                  chk("mem_req_op", 64'(mem_req_op), 64'(m.op));
                  chk("mem_req_mask", 64'(mem_req_mask), 64'(m.mask));
                  chk("mem_req_addr", mem_req_addr, m.addr);
                  if (m.op == MEMOP_STORE)
                     chk("mem_req_wdata", mem_req_wdata, m.wdata);
               end
            end
            if (i_resp_valid || d_resp_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL resp: got pulse i=%0b d=%0b expected none",
                           i_resp_valid, d_resp_valid);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_owner", 64'({i_resp_valid, d_resp_valid}),
                      64'(e.fetch ? 2'b10 : 2'b01));
                  if (e.fetch) begin
                     chk("i_resp_instr", 64'(i_resp_instr), 64'(e.instr));
                     chk("i_resp_fault", 64'(i_resp_fault), 64'(e.fault));
                  end else begin
                     chk("d_resp_data", d_resp_data, e.data);
                     chk("d_resp_fault", 64'(d_resp_fault), 64'(e.fault));
                  end
                  if (ram_mode == 1 && !e.misal)
                     chk("resp_latency", 64'(cyc - e.acc_cyc), 64'd2);
                  if (ram_mode == 2 && !e.misal)
                     chk("timeout_latency", 64'(cyc - hs_cyc), 64'(TMO + 1));
               end
            end
            ew = 0;
            if (!busy) begin
               if (d_req_valid && !(streak == MAXS && i_req_valid)) ew = 1;
               else if (i_req_valid) ew = 2;
            end
            if (i_req_valid || d_req_valid || i_req_ready || d_req_ready)
               chk("grant", 64'({i_req_ready, d_req_ready}),
                   64'((ew == 2) ? 2'b10 : (ew == 1) ? 2'b01 : 2'b00));
            if (ew == 2 && streak == MAXS && d_req_valid) forced++;
            if (ew == 2 || !i_req_valid) streak = 0;
            else if (ew == 1 && streak < MAXS) streak++;
            if (i_resp_valid || d_resp_valid) busy = 1'b0;
            if (ew == 1) begin
               m.op = d_req_op;
               m.mask = d_req_mask;
               m.addr = d_req_addr;
               m.wdata = d_req_wdata;
               mreq_q.push_back(m);
               e.fetch = 1'b0;
               e.misal = 1'b0;
               e.instr = 32'd0;
               e.data = (ram_mode == 2) ? 64'd0 : ram_word(d_req_addr);
               e.fault = (ram_mode == 2) ? FAULT_TIMEOUT : ram_fault(d_req_addr);
               e.acc_cyc = cyc;
               exp_q.push_back(e);
               busy = 1'b1;
            end else if (ew == 2) begin
               e.fetch = 1'b1;
               e.misal = (i_req_addr[1:0] != 2'b00);
               e.data = 64'd0;
               e.acc_cyc = cyc;
               if (e.misal) begin
                  e.instr = 32'd0;
                  e.fault = FAULT_MISALIGNED;
               end else begin
                  a = {i_req_addr[63:3], 3'b000};
                  m.op = MEMOP_LOAD;
                  m.mask = 8'hFF;
                  m.addr = a;
                  m.wdata = 64'd0;
                  mreq_q.push_back(m);
                  w = (ram_mode == 2) ? 64'd0 : ram_word(a);
                  e.instr = i_req_addr[2] ? w[63:32] : w[31:0];
                  e.fault = (ram_mode == 2) ? FAULT_TIMEOUT : ram_fault(a);
               end
               exp_q.push_back(e);
               busy = 1'b1;
            end
         end
      end
   end

   task automatic do_fetch(input logic [63:0] pc);
      int n = 0;
      i_req_valid = 1'b1;
      i_req_addr = pc;
      do begin
         @(negedge CLK);
         n++;
      end while (!i_req_ready && n < 500);
      if (!i_req_ready) begin
         checks++;
         errors++;
         $display("FAIL fetch_accept: got no ready after %0d cycles", n);
      end
      @(posedge CLK);
      #1;
      i_req_valid = 1'b0;
   endtask

   task automatic do_data(input logic [1:0] op, input logic [7:0] mask,
                          input logic [63:0] addr, input logic [63:0] wd);
      int n = 0;
      d_req_valid = 1'b1;
      d_req_op = op;
      d_req_mask = mask;
      d_req_addr = addr;
      d_req_wdata = wd;
      do begin
         @(negedge CLK);
         n++;
      end while (!d_req_ready && n < 500);
      if (!d_req_ready) begin
         checks++;
         errors++;
         $display("FAIL data_accept: got no ready after %0d cycles", n);
      end
      @(posedge CLK);
      #1;
      d_req_valid = 1'b0;
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 500) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (busy || exp_q.size() != 0) begin
         errors++;
         $display("FAIL quiet: got pending transaction after %0d cycles", n);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge CLK);
      chk({tag, "_valids"}, 64'({i_req_ready, d_req_ready, i_resp_valid,
                                 d_resp_valid, mem_req_valid}), 64'd0);
      chk({tag, "_mem_req"}, mem_req_addr | mem_req_wdata |
          64'({mem_req_op, mem_req_mask}), 64'd0);
      chk({tag, "_resp"}, d_resp_data | 64'(i_resp_instr) |
          64'({i_resp_fault, d_resp_fault}), 64'd0);
      chk({tag, "_err"}, 64'(err_unexpected_resp), 64'd0);
   endtask

   task automatic rand_fetches(input int n);
      logic [63:0] pc;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge CLK);
            #1;
         end
         pc = {32'd0, $urandom};
         if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
         else pc[1:0] = 2'($urandom_range(1, 3));
         do_fetch(pc);
      end
   endtask

   task automatic rand_datas(input int n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge CLK);
            #1;
         end
         do_data(2'($urandom_range(0, 2)), 8'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom});
      end
   endtask

   initial begin : watchdog
      repeat (20000) @(posedge CLK);
      checks++;
      errors++;
      $display("FAIL watchdog: got no end within 20000 cycles");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : main
      int f0;
      repeat (3) @(posedge CLK);
      check_reset_outputs("reset");
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;

      ram_mode = 1;
      do_fetch(64'h1004);
      wait_quiet();

      fork
         do_fetch(64'h3000);
         do_data(MEMOP_STORE, 8'h0F, 64'h2000, 64'h1122_3344_5566_7788);
      join
      wait_quiet();

      f0 = forced;
      fork
         repeat (10) do_data(MEMOP_LOAD, 8'hFF, 64'h4F0, 64'd0);
         begin
            do_fetch(64'h5000);
            do_fetch(64'h5008);
         end
      join
      wait_quiet();
      chk("streak_forced_fetch", 64'(forced - f0), 64'd2);

      do_fetch(64'h1002);
      wait_quiet();

      ram_mode = 0;
      fork
         rand_fetches(40);
         rand_datas(40);
      join
      wait_quiet();
      chk("err_clean", 64'(err_unexpected_resp), 64'd0);

      ram_mode = 2;
      do_data(MEMOP_LOAD, 8'hFF, 64'h6000, 64'd0);
      wait_quiet();
      inject_req++;
      repeat (3) @(negedge CLK);
      chk("err_after_late", 64'(err_unexpected_resp), 64'd1);
      @(posedge CLK);
      #1;

      do_data(MEMOP_LOAD, 8'hFF, 64'h7000, 64'd0);
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
      check_reset_outputs("midreset");
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      inject_req++;
      repeat (3) @(negedge CLK);
      chk("err_after_reset_late", 64'(err_unexpected_resp), 64'd1);
      @(posedge CLK);
      #1;

      ram_mode = 1;
      do_fetch(64'h1004);
      wait_quiet();
      do_data(MEMOP_STORE, 8'h3C, 64'h8008, 64'hCAFE_F00D_0BAD_BEEF);
      wait_quiet();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
